// File: rtl/soft_reset_requester.sv
// Initiator side of the soft-reset path: accepts a keyed request, strobes the reset
// generator after a hold-off, then follows its long reset through assertion and release.
module soft_reset_requester #(
   parameter logic [31:0] KEY            = 32'h5AFE_0001,
   parameter int unsigned ACK_HOLDOFF    = 16,
   parameter int unsigned ASSERT_TIMEOUT = 4096,
   parameter int unsigned CNT_BITS       = 16
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                req_i,
   input  logic [31:0]         key_i,
   input  logic                clear_err_i,
   input  logic                reset_status_i,
   output logic                ack_o,
   output logic                nack_o,
   output logic                soft_reset_o,
   output logic                busy_o,
   output logic                timeout_err_o,
   output logic [CNT_BITS-1:0] reset_cnt_o,
   output logic [7:0]          reject_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLDOFF,
      S_FIRE,
      S_WAIT_ASSERT,
      S_WAIT_RELEASE
   } state_t;

   // One timer serves both the hold-off countdown and the assertion timeout.
   localparam int unsigned TMR_BITS = 16;
   localparam logic [TMR_BITS-1:0] HOLDOFF_LOAD = TMR_BITS'(ACK_HOLDOFF - 1);
   localparam logic [TMR_BITS-1:0] TIMEOUT_LAST = TMR_BITS'(ASSERT_TIMEOUT - 2);
   localparam logic [TMR_BITS-1:0] TMR_ONE      = TMR_BITS'(1);

   state_t              state_q;
   state_t              state_d;
   logic [TMR_BITS-1:0] tmr_q;
   logic [TMR_BITS-1:0] tmr_d;

   logic ack_d;
   logic nack_d;
   logic soft_reset_d;
   logic busy_d;

   logic accept;
   logic refuse;
   logic timeout_hit;
   logic release_seen;

   assign accept       = req_i && (state_q == S_IDLE) && (key_i == KEY);
   assign refuse       = req_i && !accept;
   assign timeout_hit  = (state_q == S_WAIT_ASSERT) && !reset_status_i && (tmr_q == TIMEOUT_LAST);
   assign release_seen = (state_q == S_WAIT_RELEASE) && !reset_status_i;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_HOLDOFF;
               tmr_d   = HOLDOFF_LOAD;
            end
         end
         S_HOLDOFF: begin
            if (tmr_q == '0) begin
               state_d = S_FIRE;
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end
         S_FIRE: begin
            state_d = S_WAIT_ASSERT;
            tmr_d   = '0;
         end
         S_WAIT_ASSERT: begin
            if (reset_status_i) begin
               state_d = S_WAIT_RELEASE;
               tmr_d   = '0;
            end else if (timeout_hit) begin
               state_d = S_IDLE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TMR_ONE;
            end
         end
         S_WAIT_RELEASE: begin
            // No timeout here: the generator's long reset runs for millions of cycles.
            if (!reset_status_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            tmr_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so the strobe and
   // busy flag appear in the same cycle as the state they describe.
   always_comb begin
      ack_d        = accept;
      nack_d       = refuse;
      soft_reset_d = (state_d == S_FIRE);
      busy_d       = (state_d != S_IDLE);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         ack_o        <= 1'b0;
         nack_o       <= 1'b0;
         soft_reset_o <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         ack_o        <= ack_d;
         nack_o       <= nack_d;
         soft_reset_o <= soft_reset_d;
         busy_o       <= busy_d;
      end
   end

   // Status counters: a new timeout beats a clear, a clear beats a refusal.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         timeout_err_o <= 1'b0;
         reset_cnt_o   <= '0;
         reject_cnt_o  <= '0;
      end else begin
         if (timeout_hit) begin
            timeout_err_o <= 1'b1;
         end else if (clear_err_i) begin
            timeout_err_o <= 1'b0;
         end

         if (release_seen && (reset_cnt_o != '1)) begin
            reset_cnt_o <= reset_cnt_o + CNT_BITS'(1);
         end

         if (clear_err_i) begin
            reject_cnt_o <= '0;
         end else if (refuse && (reject_cnt_o != 8'hFF)) begin
            reject_cnt_o <= reject_cnt_o + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_soft_reset_requester.sv
// Directed bench for soft_reset_requester: a timestamp-based model checked every
// cycle, plus literal expectations at the cycles the scenarios call out.
module tb_soft_reset_requester;

   localparam logic [31:0] KEY = 32'h5AFE_0001;
   localparam int H  = 16;
   localparam int T  = 4096;
   localparam int CB = 16;
   localparam int RCNT_MAX = (1 << CB) - 1;

   logic          clock_i = 1'b0;
   logic          reset_i;
   logic          req_i;
   logic [31:0]   key_i;
   logic          clear_err_i;
   logic          reset_status_i;
   logic          ack_o;
   logic          nack_o;
   logic          soft_reset_o;
   logic          busy_o;
   logic          timeout_err_o;
   logic [CB-1:0] reset_cnt_o;
   logic [7:0]    reject_cnt_o;

   soft_reset_requester #(
      .KEY(KEY), .ACK_HOLDOFF(H), .ASSERT_TIMEOUT(T), .CNT_BITS(CB)
   ) dut (
      .clock_i       (clock_i),
      .reset_i       (reset_i),
      .req_i         (req_i),
      .key_i         (key_i),
      .clear_err_i   (clear_err_i),
      .reset_status_i(reset_status_i),
      .ack_o         (ack_o),
      .nack_o        (nack_o),
      .soft_reset_o  (soft_reset_o),
      .busy_o        (busy_o),
      .timeout_err_o (timeout_err_o),
      .reset_cnt_o   (reset_cnt_o),
      .reject_cnt_o  (reject_cnt_o)
   );

   always #5 clock_i = ~clock_i;

   int cyc = 0;
   always @(posedge clock_i) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int strobes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: an accepted request at cycle c schedules the strobe at c+1+H; the
   // generator must be seen high within cycles strobe+1 .. strobe+T-1.
   bit model_valid = 1'b0;
   bit m_active    = 1'b0;
   bit m_asserted  = 1'b0;
   int m_strobe    = -1;
   int m_rcnt      = 0;
   int m_rej       = 0;
   bit m_terr      = 1'b0;
   bit exp_ack     = 1'b0;
   bit exp_nack    = 1'b0;
   bit exp_strobe  = 1'b0;

   always @(negedge clock_i) begin
      bit accept;
      bit refuse;
      bit timeout_now;
      if (model_valid) begin
         check("ack_o",         32'(ack_o),         32'(exp_ack));
         check("nack_o",        32'(nack_o),        32'(exp_nack));
         check("soft_reset_o",  32'(soft_reset_o),  32'(exp_strobe));
         check("busy_o",        32'(busy_o),        32'(m_active));
         check("timeout_err_o", 32'(timeout_err_o), 32'(m_terr));
         check("reset_cnt_o",   32'(reset_cnt_o),   32'(m_rcnt));
         check("reject_cnt_o",  32'(reject_cnt_o),  32'(m_rej));
      end
      if (soft_reset_o === 1'b1) strobes++;

      if (reset_i) begin
         m_active = 0; m_asserted = 0; m_strobe = -1;
         m_rcnt = 0; m_rej = 0; m_terr = 0;
         exp_ack = 0; exp_nack = 0; exp_strobe = 0;
      end else begin
         accept      = req_i && !m_active && (key_i == KEY);
         refuse      = req_i && !accept;
         timeout_now = 0;
         exp_ack     = accept;
         exp_nack    = refuse;
         exp_strobe  = 0;
         if (accept) begin
            m_active   = 1;
            m_asserted = 0;
            m_strobe   = cyc + 1 + H;
         end else if (m_active) begin
            if (cyc + 1 == m_strobe) exp_strobe = 1;
            if (cyc > m_strobe) begin
               if (!m_asserted) begin
                  if (reset_status_i) m_asserted = 1;
                  else if (cyc == m_strobe + T - 1) begin
                     timeout_now = 1;
                     m_active    = 0;
                  end
               end else if (!reset_status_i) begin
                  if (m_rcnt != RCNT_MAX) m_rcnt++;
                  m_active = 0;
               end
            end
         end
         if (clear_err_i) m_rej = 0;
         else if (refuse && m_rej < 255) m_rej++;
         if (timeout_now) m_terr = 1;
         else if (clear_err_i) m_terr = 0;
      end
      model_valid = 1'b1;
   end

   task automatic go_to(input int c);
      while (cyc < c) begin
         @(posedge clock_i);
         #1;
      end
   endtask

   task automatic at(input int c);
      go_to(c);
      @(negedge clock_i);
      #1;
   endtask

   task automatic pulse_req(input int c, input logic [31:0] k);
      go_to(c);
      req_i = 1'b1;
      key_i = k;
      go_to(c + 1);
      req_i = 1'b0;
   endtask

   task automatic pulse_clear(input int c);
      go_to(c);
      clear_err_i = 1'b1;
      go_to(c + 1);
      clear_err_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1; req_i = 1'b0; key_i = '0; clear_err_i = 1'b0; reset_status_i = 1'b0;
      go_to(3);
      reset_i = 1'b0;
      at(3);
      check("reset busy",    32'(busy_o), 0);
      check("reset rcnt",    32'(reset_cnt_o), 0);
      check("reset reject",  32'(reject_cnt_o), 0);
      check("reset timeout", 32'(timeout_err_o), 0);

      // Good key: ack at 11, strobe only at 27, generator high 1050..4999.
      pulse_req(10, KEY);
      at(11);
      check("good ack@11", 32'(ack_o), 1);
      check("good busy@11", 32'(busy_o), 1);
      at(26);
      check("no strobe@26", 32'(soft_reset_o), 0);
      at(27);
      check("strobe@27", 32'(soft_reset_o), 1);
      at(28);
      check("one strobe", 32'(strobes), 1);
      go_to(1050);
      reset_status_i = 1'b1;

      // Second request during WAIT_RELEASE is refused.
      pulse_req(2000, KEY);
      at(2001);
      check("busy nack@2001", 32'(nack_o), 1);
      check("busy no ack@2001", 32'(ack_o), 0);
      check("busy reject@2001", 32'(reject_cnt_o), 1);

      go_to(5000);
      reset_status_i = 1'b0;
      at(5000);
      check("rcnt@5000", 32'(reset_cnt_o), 0);
      at(5001);
      check("rcnt@5001", 32'(reset_cnt_o), 1);
      check("idle@5001", 32'(busy_o), 0);

      // Bad key.
      pulse_clear(5005);
      at(5006);
      check("cleared reject", 32'(reject_cnt_o), 0);
      pulse_req(5010, 32'h0);
      at(5011);
      check("badkey nack", 32'(nack_o), 1);
      check("badkey reject", 32'(reject_cnt_o), 1);
      check("badkey busy", 32'(busy_o), 0);
      at(5040);
      check("badkey no strobe", 32'(strobes), 1);

      // Generator never responds: strobe 5117, timeout 4096 cycles later.
      pulse_req(5100, KEY);
      at(5117);
      check("strobe@5117", 32'(soft_reset_o), 1);
      at(9212);
      check("no timeout@9212", 32'(timeout_err_o), 0);
      check("busy@9212", 32'(busy_o), 1);
      at(9213);
      check("timeout@9213", 32'(timeout_err_o), 1);
      check("idle@9213", 32'(busy_o), 0);
      check("rcnt kept", 32'(reset_cnt_o), 1);
      pulse_clear(9220);
      at(9221);
      check("timeout cleared", 32'(timeout_err_o), 0);

      // Timeout in the same cycle as a clear: the set wins.
      pulse_req(9300, KEY);
      pulse_clear(13412);
      at(13413);
      check("timeout beats clear", 32'(timeout_err_o), 1);
      check("idle@13413", 32'(busy_o), 0);

      // Generator already in reset when the strobe fires.
      go_to(13500);
      reset_status_i = 1'b1;
      pulse_req(13500, KEY);
      at(13517);
      check("strobe@13517", 32'(soft_reset_o), 1);
      go_to(13530);
      reset_status_i = 1'b0;
      at(13531);
      check("rcnt@13531", 32'(reset_cnt_o), 2);
      check("idle@13531", 32'(busy_o), 0);

      // 300 back-to-back bad requests saturate the reject counter.
      go_to(13600);
      req_i = 1'b1;
      key_i = 32'hDEAD_BEEF;
      go_to(13900);
      req_i = 1'b0;
      at(13900);
      check("reject sat", 32'(reject_cnt_o), 255);
      check("held nack", 32'(nack_o), 1);
      at(13901);
      check("nack ends", 32'(nack_o), 0);
      go_to(13910);
      req_i = 1'b1; key_i = 32'h0; clear_err_i = 1'b1;
      go_to(13911);
      req_i = 1'b0; clear_err_i = 1'b0;
      at(13911);
      check("clear beats reject", 32'(reject_cnt_o), 0);
      check("nack with clear", 32'(nack_o), 1);

      // Reset during HOLDOFF cancels the strobe and clears everything.
      pulse_req(14000, KEY);
      at(14001);
      check("ack@14001", 32'(ack_o), 1);
      go_to(14005);
      reset_i = 1'b1;
      go_to(14006);
      reset_i = 1'b0;
      at(14006);
      check("rst busy",    32'(busy_o), 0);
      check("rst strobe",  32'(soft_reset_o), 0);
      check("rst rcnt",    32'(reset_cnt_o), 0);
      check("rst timeout", 32'(timeout_err_o), 0);
      at(14040);
      check("total strobes", 32'(strobes), 4);
      check("still idle", 32'(busy_o), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
